// File: rtl/instruction_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage_if
// Bundles the fetch stage's bus signals: redirect/stall requests from the
// decode/hazard logic, the program ROM address/data pair and the IF/ID
// pipeline register outputs.
//   slave  : view of the fetch stage itself (requests and ROM data in,
//            PC / ROM address / IF/ID contents out)
//   master : view of the surrounding pipeline and ROM (drives requests and
//            ROM data, observes fetch outputs)
// -----------------------------------------------------------------------------
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall;
  logic                  BranchTaken;
  logic [15:0]           BranchImm;
  logic                  Jump;
  logic [25:0]           JumpIndex;
  logic                  JumpReg;
  logic [DATA_WIDTH-1:0] RegTarget;
  logic [DATA_WIDTH-1:0] ID_PC_Plus4;
  logic [DATA_WIDTH-1:0] Instruction_IF;
  logic [DATA_WIDTH-1:0] ROM_Address;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] Instruction_ID;
  logic [DATA_WIDTH-1:0] PC_Plus4_ID;
  logic                  Valid_ID;
  logic                  AlignErr;

  modport slave (
    input  Stall, BranchTaken, BranchImm, Jump, JumpIndex, JumpReg,
           RegTarget, ID_PC_Plus4, Instruction_IF,
    output ROM_Address, PC, Instruction_ID, PC_Plus4_ID, Valid_ID, AlignErr
  );

  modport master (
    output Stall, BranchTaken, BranchImm, Jump, JumpIndex, JumpReg,
           RegTarget, ID_PC_Plus4, Instruction_IF,
    input  ROM_Address, PC, Instruction_ID, PC_Plus4_ID, Valid_ID, AlignErr
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
// Owns the program counter, drives the asynchronous program ROM address and
// captures the fetched instruction into the IF/ID pipeline register. Stall
// holds the stage; any redirect (jr > j > branch) loads the target PC and
// flushes the wrong-path fetch with a NOP bubble.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instruction_fetch_stage_if.slave (requests, ROM data, outputs)
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_stage_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);
  localparam logic [DATA_WIDTH-1:0] ZERO_W  = DATA_WIDTH'(32'd0);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_plus4;
  logic                  r_valid;
  logic                  r_align_err;

  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_instr_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus4_nxt;
  logic                  w_valid_nxt;
  logic                  w_align_err_nxt;

  logic                  w_redirect;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_branch_off;
  logic [DATA_WIDTH-1:0] w_target;

  assign w_redirect   = bus.JumpReg | bus.Jump | bus.BranchTaken;
  assign w_pc_plus4   = r_pc + PC_STEP;
  // Sign-extended word offset; the add below wraps modulo 2^DATA_WIDTH.
  assign w_branch_off = {{(DATA_WIDTH-18){bus.BranchImm[15]}}, bus.BranchImm, 2'b00};

  // Redirect target selection, jr has priority over j over branch.
  always_comb begin
    w_target = ZERO_W;
    if (bus.JumpReg) begin
      w_target = {bus.RegTarget[DATA_WIDTH-1:2], 2'b00};
    end else if (bus.Jump) begin
      w_target = {bus.ID_PC_Plus4[DATA_WIDTH-1:28], bus.JumpIndex, 2'b00};
    end else begin
      w_target = bus.ID_PC_Plus4 + w_branch_off;
    end
  end

  // Next-state and next-datapath values; FILL and RUN share the datapath rules.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_pc_plus4_nxt  = r_pc_plus4;
    w_valid_nxt     = r_valid;
    w_align_err_nxt = 1'b0;

    if (w_redirect) begin
      // Flush the wrong-path fetch; redirect wins over Stall.
      w_pc_nxt        = w_target;
      w_instr_nxt     = NOP_WORD;
      w_pc_plus4_nxt  = ZERO_W;
      w_valid_nxt     = 1'b0;
      w_align_err_nxt = bus.JumpReg & (|bus.RegTarget[1:0]);
    end else if (bus.Stall) begin
      w_pc_nxt        = r_pc;
    end else begin
      w_pc_nxt        = w_pc_plus4;
      w_instr_nxt     = bus.Instruction_IF;
      w_pc_plus4_nxt  = w_pc_plus4;
      w_valid_nxt     = 1'b1;
    end

    case (r_state)
      ST_FILL: begin
        if (w_redirect || !bus.Stall) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State, PC and IF/ID register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FILL;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_WORD;
      r_pc_plus4  <= ZERO_W;
      r_valid     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_pc_plus4  <= w_pc_plus4_nxt;
      r_valid     <= w_valid_nxt;
      r_align_err <= w_align_err_nxt;
    end
  end

  // ROM address depends only on the PC register, never on request inputs.
  assign bus.ROM_Address    = r_pc - TEXT_BASE;
  assign bus.PC             = r_pc;
  assign bus.Instruction_ID = r_instr;
  assign bus.PC_Plus4_ID    = r_pc_plus4;
  assign bus.Valid_ID       = r_valid;
  assign bus.AlignErr       = r_align_err;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pp4;
    logic        valid;
    logic        aerr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pp4;
  logic        m_valid;

  instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus();

  instruction_fetch_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0040_0000),
    .TEXT_BASE (32'h0040_0000),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.Instruction_IF = rom_word(bus.ROM_Address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.Stall       = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchImm   = 16'h0000;
    bus.Jump        = 1'b0;
    bus.JumpIndex   = 26'h000_0000;
    bus.JumpReg     = 1'b0;
    bus.RegTarget   = 32'h0000_0000;
    bus.ID_PC_Plus4 = 32'h0000_0000;
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ins   = 32'h0000_0000;
    m_pp4   = 32'h0000_0000;
    m_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_pc"},    bus.PC, 32'h0040_0000);
    check_val({tag, "_rom"},   bus.ROM_Address, 32'h0000_0000);
    check_val({tag, "_ins"},   bus.Instruction_ID, 32'h0000_0000);
    check_val({tag, "_pp4"},   bus.PC_Plus4_ID, 32'h0000_0000);
    check_val({tag, "_valid"}, {31'd0, bus.Valid_ID}, 32'd0);
    check_val({tag, "_aerr"},  {31'd0, bus.AlignErr}, 32'd0);
  endtask

  // Predict one edge from the current inputs, push it, clock, then pop and compare.
  task automatic step();
    exp_t        e;
    logic [31:0] tgt;
    e.aerr = 1'b0;
    if (bus.JumpReg | bus.Jump | bus.BranchTaken) begin
      if (bus.JumpReg)   tgt = {bus.RegTarget[31:2], 2'b00};
      else if (bus.Jump) tgt = {bus.ID_PC_Plus4[31:28], bus.JumpIndex, 2'b00};
      else               tgt = bus.ID_PC_Plus4 + {{14{bus.BranchImm[15]}}, bus.BranchImm, 2'b00};
      e.aerr  = bus.JumpReg & (bus.RegTarget[1:0] != 2'b00);
      m_pc    = tgt;
      m_ins   = 32'h0000_0000;
      m_pp4   = 32'h0000_0000;
      m_valid = 1'b0;
    end else if (!bus.Stall) begin
      m_ins   = rom_word(m_pc - TEXT_BASE);
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    e.pc = m_pc; e.ins = m_ins; e.pp4 = m_pp4; e.valid = m_valid;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_val("sb_pc",    bus.PC, e.pc);
    check_val("sb_rom",   bus.ROM_Address, e.pc - TEXT_BASE);
    check_val("sb_ins",   bus.Instruction_ID, e.ins);
    check_val("sb_pp4",   bus.PC_Plus4_ID, e.pp4);
    check_val("sb_valid", {31'd0, bus.Valid_ID}, {31'd0, e.valid});
    check_val("sb_aerr",  {31'd0, bus.AlignErr}, {31'd0, e.aerr});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // Sequential fetch out of FILL.
    step();
    check_val("seq_pc",    bus.PC, 32'h0040_0004);
    check_val("seq_rom",   bus.ROM_Address, 32'h0000_0004);
    check_val("seq_ins",   bus.Instruction_ID, 32'h2008_0005);
    check_val("seq_pp4",   bus.PC_Plus4_ID, 32'h0040_0004);
    check_val("seq_valid", {31'd0, bus.Valid_ID}, 32'd1);
    step();

    // Stall for three edges at 0x0040_0008.
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_pc", bus.PC, 32'h0040_0008);
      check_val("stall_ins", bus.Instruction_ID, rom_word(32'h0000_0004));
    end
    bus.Stall = 1'b0;
    step();
    check_val("resume_pc", bus.PC, 32'h0040_000C);

    // Backward branch.
    bus.BranchTaken = 1'b1;
    bus.BranchImm   = 16'hFFFD;
    bus.ID_PC_Plus4 = 32'h0040_0010;
    step();
    check_val("br_pc",    bus.PC, 32'h0040_0004);
    check_val("br_ins",   bus.Instruction_ID, 32'h0000_0000);
    check_val("br_valid", {31'd0, bus.Valid_ID}, 32'd0);
    idle();
    step();

    // jr + j + Stall together: jr wins, misaligned target flags AlignErr.
    bus.JumpReg   = 1'b1;
    bus.RegTarget = 32'h0040_0022;
    bus.Jump      = 1'b1;
    bus.JumpIndex = 26'h010_0008;
    bus.Stall     = 1'b1;
    step();
    check_val("prio_pc",    bus.PC, 32'h0040_0020);
    check_val("prio_aerr",  {31'd0, bus.AlignErr}, 32'd1);
    check_val("prio_valid", {31'd0, bus.Valid_ID}, 32'd0);
    idle();
    step();
    check_val("prio_aerr_drop", {31'd0, bus.AlignErr}, 32'd0);

    // Jump.
    bus.Jump        = 1'b1;
    bus.JumpIndex   = 26'h010_0010;
    bus.ID_PC_Plus4 = 32'h0040_0008;
    step();
    check_val("j_pc",    bus.PC, 32'h0040_0040);
    check_val("j_valid", {31'd0, bus.Valid_ID}, 32'd0);
    idle();

    // PC wrap from 0xFFFF_FFFC and ROM address below TEXT_BASE.
    bus.JumpReg   = 1'b1;
    bus.RegTarget = 32'hFFFF_FFFC;
    step();
    idle();
    step();
    check_val("wrap_pc",  bus.PC, 32'h0000_0000);
    check_val("wrap_rom", bus.ROM_Address, 32'hFFC0_0000);
    check_val("wrap_pp4", bus.PC_Plus4_ID, 32'h0000_0000);
    step();

    // Random mix of stalls and redirects.
    for (int i = 0; i < 60; i++) begin
      idle();
      bus.Stall       = ($urandom_range(0, 3) == 0);
      bus.BranchTaken = ($urandom_range(0, 5) == 0);
      bus.Jump        = ($urandom_range(0, 7) == 0);
      bus.JumpReg     = ($urandom_range(0, 7) == 0);
      bus.BranchImm   = 16'($urandom);
      bus.JumpIndex   = 26'($urandom);
      bus.RegTarget   = 32'($urandom);
      bus.ID_PC_Plus4 = 32'h0040_0000 + {20'd0, 10'($urandom), 2'b00};
      step();
    end
    idle();

    // Reset mid-run: reach PC=0x0040_0030 with Valid_ID=1, then drop reset between edges.
    bus.Jump        = 1'b1;
    bus.JumpIndex   = 26'h010_000B;
    bus.ID_PC_Plus4 = 32'h0040_0000;
    step();
    idle();
    step();
    check_val("pre_rst_pc",    bus.PC, 32'h0040_0030);
    check_val("pre_rst_valid", {31'd0, bus.Valid_ID}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.Stall = 1'b1;
    step();
    check_val("fill_stall_pc",    bus.PC, 32'h0040_0000);
    check_val("fill_stall_valid", {31'd0, bus.Valid_ID}, 32'd0);
    bus.Stall = 1'b0;
    step();
    check_val("refill_pc",  bus.PC, 32'h0040_0004);
    check_val("refill_ins", bus.Instruction_ID, 32'h2008_0005);
    check_val("refill_valid", {31'd0, bus.Valid_ID}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
